// File: rtl/apb_pkg.sv
// Shared types and widths for the APB register completer.
package apb_pkg;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam logic [APB_DATA_W-1:0] APB_RESET_VAL = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_state_t;
endpackage

// File: rtl/apb_regfile.sv
// NUM_REGS x 8-bit register bank: one synchronous write port, one async read port.
// Out-of-range reads return zero and out-of-range writes are dropped.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = APB_RESET_VAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [APB_ADDR_W-1:0] waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_ADDR_W-1:0] raddr,
  output logic [APB_DATA_W-1:0] rdata,
  output logic [APB_DATA_W-1:0] reg0
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [APB_ADDR_W:0] LIMIT = (APB_ADDR_W + 1)'(NUM_REGS);

  logic [APB_DATA_W-1:0] mem [NUM_REGS];
  logic                  w_ok;
  logic                  r_ok;

  assign w_ok = ({1'b0, waddr} < LIMIT);
  assign r_ok = ({1'b0, raddr} < LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (we && w_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = r_ok ? mem[raddr[IDX_W-1:0]] : '0;
  assign reg0  = mem[0];
endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a small register bank and WAIT_CYCLES wait states per access.
// Optional macro APB_SLVERR_EN adds pslverr for out-of-range addresses.
//
// state | meaning
// IDLE  | waiting for a setup phase; latches address/data/direction
// WAIT  | access phase with pready low, counting down wait states
// READY | pready high for one cycle; write commits at the closing edge
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = APB_RESET_VAL
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic                  pready,
  output logic [APB_DATA_W-1:0] prdata,
  output logic [APB_DATA_W-1:0] ctrl_out
`ifdef APB_SLVERR_EN
  ,
  output logic                  pslverr
`endif
);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [APB_ADDR_W:0] LIMIT = (APB_ADDR_W + 1)'(NUM_REGS);

  apb_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  pready_d;
  logic [APB_DATA_W-1:0] prdata_d;
  logic [APB_ADDR_W-1:0] rd_addr;
  logic [APB_DATA_W-1:0] rd_data;
  logic                  rd_in_range;
  logic                  we;

  // Read port looks at the live bus in IDLE so zero-wait reads load prdata at setup.
  assign rd_addr     = (state_q == IDLE) ? paddr : addr_q;
  assign rd_in_range = ({1'b0, rd_addr} < LIMIT);
  assign we          = (state_q == READY) && psel && penable && write_q && rd_in_range;

  apb_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (rd_data),
    .reg0  (ctrl_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    pready_d = 1'b0;
    prdata_d = prdata;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          if (WAIT_CYCLES == 0) begin
            state_d  = READY;
            pready_d = 1'b1;
            if (!pwrite) prdata_d = rd_data;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = READY;
          pready_d = 1'b1;
          if (!write_q) prdata_d = rd_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      pready  <= pready_d;
      prdata  <= prdata_d;
    end
  end

`ifdef APB_SLVERR_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) pslverr <= 1'b0;
    else          pslverr <= pready_d && !rd_in_range;
  end
`endif
endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave with three instances at WAIT_CYCLES 0, 1 and 3.
module tb_apb_reg_slave;
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [2:0] psel = '0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [2:0] pready_v;
  logic [7:0] prdata_v [3];
  logic [7:0] ctrl_v [3];

  localparam int WC [3] = '{0, 1, 3};

  int total = 0;
  int bad = 0;
  logic [7:0] model [3][16];
  logic [7:0] exp_q [$];

  always #5 pclk = ~pclk;

  apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]), .ctrl_out(ctrl_v[0]));
  apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(1)) u_dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]), .ctrl_out(ctrl_v[1]));
  apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(3)) u_dut2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2]), .ctrl_out(ctrl_v[2]));

  // One transfer on DUT d; psel stays high afterwards so a following call is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input bit scramble);
    int n;
    logic [7:0] exp;
    @(posedge pclk); #1;
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    if (!wr) exp_q.push_back((a < 8'd16) ? model[d][a[3:0]] : 8'h00);
    @(posedge pclk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr = ~a;
      pwdata = ~wd;
      pwrite = ~wr;
    end
    n = 1;
    @(negedge pclk);
    while (!pready_v[d] && n < 20) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (pready_v[d] !== 1'b1) begin
      bad++;
      $display("FAIL timeout dut%0d addr=%h: pready=%b after %0d cycles, required 1", d, a, pready_v[d], n);
    end else if (n != WC[d] + 1) begin
      bad++;
      $display("FAIL latency dut%0d addr=%h: pready in access cycle %0d, required %0d", d, a, n, WC[d] + 1);
    end
    if (!wr) begin
      exp = exp_q.pop_front();
      total++;
      if (prdata_v[d] !== exp) begin
        bad++;
        $display("FAIL rdata dut%0d addr=%h: prdata=%h, required %h", d, a, prdata_v[d], exp);
      end
    end else if (a < 8'd16) begin
      model[d][a[3:0]] = wd;
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = '0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (pready_v[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_pready dut%0d: got %b, required 0", d, pready_v[d]);
      end
      total++;
      if (prdata_v[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_prdata dut%0d: got %h, required 00", d, prdata_v[d]);
      end
      total++;
      if (ctrl_v[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d: got %h, required 00", d, ctrl_v[d]);
      end
    end
  endtask

  task automatic test_write_read();
    xfer(1, 1'b1, 8'h03, 8'hA5, 1'b0);
    bus_idle();
    @(negedge pclk);
    total++;
    if (pready_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL pready_one_cycle: got %b, required 0", pready_v[1]);
    end
    xfer(1, 1'b0, 8'h03, 8'h00, 1'b0);
    bus_idle();
  endtask

  task automatic test_ctrl_out();
    xfer(0, 1'b1, 8'h00, 8'h3C, 1'b0);
    total++;
    if (ctrl_v[0] !== 8'h00) begin
      bad++;
      $display("FAIL ctrl_early: got %h, required 00", ctrl_v[0]);
    end
    bus_idle();
    @(negedge pclk);
    total++;
    if (ctrl_v[0] !== 8'h3C) begin
      bad++;
      $display("FAIL ctrl_out: got %h, required 3c", ctrl_v[0]);
    end
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0);
    bus_idle();
  endtask

  task automatic test_out_of_range();
    xfer(1, 1'b0, 8'h20, 8'h00, 1'b0);
    xfer(1, 1'b1, 8'h20, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) xfer(1, 1'b0, 8'(i), 8'h00, 1'b0);
    bus_idle();
  endtask

  task automatic test_abort();
    bit seen;
    @(posedge pclk); #1;
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h05;
    pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = '0;
    penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (pready_v[2] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_pready: got 1, required 0");
    end
    xfer(2, 1'b0, 8'h05, 8'h00, 1'b0);
    xfer(2, 1'b1, 8'h05, 8'h5A, 1'b1);
    xfer(2, 1'b0, 8'h05, 8'h00, 1'b0);
    bus_idle();
  endtask

  task automatic test_back_to_back();
    xfer(1, 1'b1, 8'h01, 8'h11, 1'b0);
    xfer(1, 1'b1, 8'h02, 8'h22, 1'b1);
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0);
    xfer(1, 1'b0, 8'h02, 8'h00, 1'b0);
    bus_idle();
  endtask

  task automatic test_reset_mid();
    @(posedge pclk); #1;
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h04;
    pwdata = 8'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(negedge pclk);
    total++;
    if (pready_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_pready: got %b, required 0", pready_v[2]);
    end
    total++;
    if (prdata_v[2] !== 8'h00) begin
      bad++;
      $display("FAIL midreset_prdata: got %h, required 00", prdata_v[2]);
    end
    total++;
    if (ctrl_v[0] !== 8'h00) begin
      bad++;
      $display("FAIL midreset_ctrl: got %h, required 00", ctrl_v[0]);
    end
    psel = '0;
    penable = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(2, 1'b0, 8'h04, 8'h00, 1'b0);
    xfer(2, 1'b0, 8'h05, 8'h00, 1'b0);
    bus_idle();
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    test_reset();
    test_write_read();
    test_ctrl_out();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
